test_value_uart_monitor: RTL and testbench
==========================================

# test_value_uart_monitor

Downstream debug stage for the single-cycle RISC core: consumes the core's 16-bit `test_value` output, detects every change, buffers changed values in a small FIFO, and streams each one off-chip as an ASCII line ("XXXX\r\n", uppercase hex) over an 8N1 UART transmitter. It lets a board run report register/memory results without a logic analyser.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Minimum 2.
- `FIFO_DEPTH`, default 4: entries of 16 bits. Must be a power of two, at least 2.

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `test_value`  input  16: value to monitor, taken directly from the core.
- `en`  input  1: capture enable. Changes are ignored while low.
- `tx`  output  1: UART serial line. Idles high.
- `busy`  output  1: high while a frame is in flight or the FIFO is non-empty.
- `overflow`  output  1: sticky. Set when a change is dropped because the FIFO is full.
- `fifo_count`  output  $clog2(FIFO_DEPTH)+1: number of stored entries.

## Operation
- Reset values (asynchronous, while `rst`=0):
  - `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0.
  - Previous-value register = 0x0000.
  - FSM = IDLE, bit and character counters = 0.
- Change detect:
  - The previous-value register loads `test_value` every cycle, regardless of `en`.
  - A push is requested on any edge where `en`=1 and `test_value` != previous value.
  - Because of the 0x0000 reset value, a nonzero value present right after reset is captured.
- FIFO:
  - A push when `fifo_count`==FIFO_DEPTH is dropped and sets `overflow`. This holds even if a pop happens on the same edge.
  - Push and pop on the same non-full edge leave `fifo_count` unchanged.
  - `overflow` clears only on reset.
- Frame format: six characters, sent in order:
  - hex digit of bits [15:12], [11:8], [7:4], [3:0];
  - then 0x0D, then 0x0A.
  - Digits 0-9 map to 0x30-0x39; digits A-F map to 0x41-0x46.
- Character format: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop into the frame register, set char index 0, go to START. Otherwise `tx`=1.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=current bit for CLKS_PER_BIT cycles. Advance bit index; after bit 7 go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. If char index < 5, increment it and go to START. Otherwise go to IDLE.
- `tx` is driven from a register (glitch-free).
- `busy` = (state != IDLE) || (`fifo_count` != 0).
- `en` low does not abort a frame in progress or flush the FIFO.

## Timing
- Change first sampled at edge E0: the push is written at E0.
- At E1 the FSM pops the entry and `tx` falls.
- `tx` rising to `fifo_count` visible: 1 cycle after the write edge.
- One character = 10*CLKS_PER_BIT cycles. One frame = 60*CLKS_PER_BIT cycles.
- Back-to-back frames: exactly 1 IDLE cycle (`tx`=1) between the end of the last stop bit and the next start bit.
- Consecutive characters within a frame have no gap.
- Reset asserted mid-frame:
  - `tx` goes high immediately; FIFO and frame are discarded.
  - After release, transmission restarts only on a new detected change.

## Test plan
- Reset, CLKS_PER_BIT=4, `en`=1, hold `test_value`=0x1234 -> `tx` falls 2 edges after release. The decoded bytes are 0x31 0x32 0x33 0x34 0x0D 0x0A. Frame spans 240 cycles, then `busy`=0.
- `test_value`=0xABCF -> bytes 0x41 0x42 0x43 0x46 0x0D 0x0A, each bit exactly 4 cycles wide.
- FIFO_DEPTH=4: while the first frame is sending, apply 6 further distinct values on consecutive cycles -> `fifo_count` reaches 4 and `overflow`=1. Exactly 5 frames are emitted in order: the first value plus the first four buffered.
- `en`=0 while `test_value` changes 0x0001 -> 0x0002, then raise `en` with the value held at 0x0002 -> no push, `tx` stays 1, `busy`=0.
- Two changes one cycle apart -> second start bit begins exactly 1 cycle after the first frame's final stop bit ends.
- Assert `rst` during DATA of the 3rd character with 2 entries queued -> `tx`=1 in the same cycle, `fifo_count`=0, `overflow`=0. No further output until a new change.

Source files
------------

// File: rtl/test_value_uart_monitor.sv
// Watches the core's test_value, queues every change, and sends each one
// as an uppercase hex ASCII line ("XXXX\r\n") on an 8N1 UART.
// Ports: clk, rst (async active-low), test_value[15:0], en,
//        tx (idles high), busy, overflow (sticky), fifo_count.
module test_value_uart_monitor #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   test_value,
  input  logic                          en,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [15:0]   prev_value;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    char_idx;
  logic [15:0]   frame;
  logic [3:0]    nib;
  logic [7:0]    char_byte;
  logic          push_req;
  logic          full;
  logic          push;
  logic          pop;
  logic          baud_end;

  assign push_req = en && (test_value != prev_value);
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign push     = push_req && !full;
  assign pop      = (state == IDLE) && (fifo_count != '0);
  assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_comb begin
    nib = 4'h0;
    case (char_idx)
      3'd0:    nib = frame[15:12];
      3'd1:    nib = frame[11:8];
      3'd2:    nib = frame[7:4];
      3'd3:    nib = frame[3:0];
      default: nib = 4'h0;
    endcase
    char_byte = 8'h00;
    case (char_idx)
      3'd4:    char_byte = 8'h0D;
      3'd5:    char_byte = 8'h0A;
      default: begin
        if (nib < 4'd10) char_byte = {4'h3, nib};
        else             char_byte = 8'h37 + {4'h0, nib};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= test_value;
  end

  // A full FIFO drops the push even when a pop frees a slot on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_value <= 16'h0000;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      prev_value <= test_value;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push_req && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      frame    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            frame    <= mem[rd_ptr];
            char_idx <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= char_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= char_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (char_idx < 3'd5) begin
              char_idx <= char_idx + 3'd1;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_value_uart_monitor.sv
// Self-checking bench for test_value_uart_monitor: UART receiver with a
// byte scoreboard, table-driven frames, and FIFO/reset/timing sequences.
module tb_test_value_uart_monitor;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] test_value = 16'h0000;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_count;

  test_value_uart_monitor #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .test_value(test_value),
    .en(en),
    .tx(tx),
    .busy(busy),
    .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  typedef struct {
    logic [15:0] v;
    logic [31:0] hex;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] hex4);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hex4[8*i +: 8]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_idle(input int max, output int cycles);
    cycles = 0;
    while (busy && cycles < max) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  // Receiver: samples at every falling clock edge, 4 samples per bit.
  logic       rx_s[40];
  logic [7:0] rx_b;
  bit         rx_ok;
  bit         rx_abort;

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        rx_s[0]  = 1'b0;
        rx_abort = 1'b0;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (rst !== 1'b1) begin
            rx_abort = 1'b1;
            break;
          end
          rx_s[k] = tx;
        end
        if (!rx_abort) begin
          rx_ok = 1'b1;
          for (int g = 0; g < 10; g++)
            for (int j = 1; j < 4; j++)
              if (rx_s[4*g+j] !== rx_s[4*g]) rx_ok = 1'b0;
          if (rx_s[36] !== 1'b1) rx_ok = 1'b0;
          for (int b = 0; b < 8; b++) rx_b[b] = rx_s[4 + 4*b];
          chk("bit_width", {31'h0, rx_ok}, 32'h1);
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_unexpected: got %h expected none", rx_b);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rx_b !== e) begin
              n_fail++;
              $display("FAIL rx_byte: got %h expected %h", rx_b, e);
            end
          end
        end
      end
    end
  end

  int c;
  int n0;
  int txlow;

  initial begin
    tbl[0] = '{16'hABCF, "ABCF"};
    tbl[1] = '{16'h09F0, "09F0"};
    tbl[2] = '{16'hFFFF, "FFFF"};
    tbl[3] = '{16'h0000, "0000"};
    tbl[4] = '{16'h5A3E, "5A3E"};

    rst = 1'b0;
    en = 1'b1;
    test_value = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    chk("rst_count", {29'h0, fifo_count}, 32'h0);

    @(negedge clk);
    push_frame("1234");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("e1_tx", {31'h0, tx}, 32'h1);
    chk("e1_count", {29'h0, fifo_count}, 32'h1);
    @(posedge clk);
    #1;
    chk("e2_tx_fall", {31'h0, tx}, 32'h0);
    chk("e2_count", {29'h0, fifo_count}, 32'h0);
    wait_idle(1000, c);
    chk("frame_len", c, 240);
    repeat (2) @(posedge clk);
    chk("sb_1234", exp_q.size(), 0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      test_value = tbl[i].v;
      push_frame(tbl[i].hex);
      @(posedge clk);
      #1;
      wait_idle(1000, c);
      chk("vec_frame_len", c, 241);
      repeat (2) @(posedge clk);
      chk("vec_sb_empty", exp_q.size(), 0);
      chk("vec_ovf", {31'h0, overflow}, 32'h0);
    end

    @(negedge clk);
    en = 1'b0;
    test_value = 16'h0001;
    @(negedge clk);
    test_value = 16'h0002;
    repeat (3) @(negedge clk);
    en = 1'b1;
    n0 = starts.size();
    txlow = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) txlow++;
    end
    chk("en_tx_low", txlow, 0);
    chk("en_busy", {31'h0, busy}, 32'h0);
    chk("en_count", {29'h0, fifo_count}, 32'h0);
    chk("en_no_chars", starts.size(), n0);

    n0 = starts.size();
    @(negedge clk);
    test_value = 16'hBEEF;
    push_frame("BEEF");
    @(negedge clk);
    test_value = 16'hC0DE;
    push_frame("C0DE");
    wait_idle(2000, c);
    repeat (2) @(posedge clk);
    chk("b2b_chars", starts.size(), n0 + 12);
    if (starts.size() >= n0 + 7) begin
      chk("b2b_char_gap", starts[n0+1] - starts[n0], 40);
      chk("b2b_frame_gap", starts[n0+6] - starts[n0], 241);
    end
    chk("b2b_sb_empty", exp_q.size(), 0);

    n0 = starts.size();
    @(negedge clk);
    test_value = 16'h1111;
    push_frame("1111");
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      test_value = 16'h2000 + 16'(k);
      if (k < 4) push_frame({"200", 8'h30 + 8'(k)});
      @(negedge clk);
    end
    chk("ovf_count", {29'h0, fifo_count}, 32'h4);
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
    wait_idle(3000, c);
    repeat (2) @(posedge clk);
    chk("ovf_sb_empty", exp_q.size(), 0);
    chk("ovf_chars", starts.size(), n0 + 30);
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);

    @(negedge clk);
    test_value = 16'h3333;
    push_frame("3333");
    @(negedge clk);
    test_value = 16'h4444;
    @(negedge clk);
    test_value = 16'h5555;
    repeat (85) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_count", {29'h0, fifo_count}, 32'h2);
    rst = 1'b0;
    test_value = 16'h0000;
    #1;
    chk("mid_rst_tx", {31'h0, tx}, 32'h1);
    chk("mid_rst_count", {29'h0, fifo_count}, 32'h0);
    chk("mid_rst_ovf", {31'h0, overflow}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n0 = starts.size();
    txlow = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) txlow++;
    end
    chk("post_rst_tx_low", txlow, 0);
    chk("post_rst_chars", starts.size(), n0);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
